// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the staged reset sequencer.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int LLC_W      = 8;
    localparam int MAX_STAGES = 8;

endpackage

// File: rtl/reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, cleared asynchronously.
module sync_bit #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[DEPTH-2:0], d};
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases up to eight active-low domain resets in order once the MMCM lock is
// stable; any lock loss or software request re-asserts all of them together.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int STAGES      = 3,
    parameter int SYNC_DEPTH  = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              locked,
    input  logic              swReset,
    output logic [STAGES-1:0] rstOut,
    output logic              ready,
    output logic [LLC_W-1:0]  lockLossCount
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
    localparam int IW   = $clog2(MAX_STAGES + 1);

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST    = IW'(STAGES - 1);

    logic          lockedS;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    sync_bit #(.DEPTH(SYNC_DEPTH)) u_lock_sync (
        .clk   (CLK),
        .rst_n (nRST),
        .d     (locked),
        .q     (lockedS)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            idx           <= '0;
            rstOut        <= '0;
            ready         <= 1'b0;
            lockLossCount <= '0;
        end else if (state == WAIT_LOCK) begin
            if (lockedS) begin
                cnt   <= HOLD_LD;
                idx   <= '0;
                state <= HOLD;
            end
        end else if (!lockedS) begin
            // Lock loss beats a simultaneous software request.
            rstOut <= '0;
            ready  <= 1'b0;
            cnt    <= '0;
            idx    <= '0;
            state  <= WAIT_LOCK;
            if (state == RUN && lockLossCount != {LLC_W{1'b1}})
                lockLossCount <= lockLossCount + 1'b1;
        end else if (swReset) begin
            rstOut <= '0;
            ready  <= 1'b0;
            cnt    <= HOLD_LD;
            idx    <= '0;
            state  <= HOLD;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == '0) begin
                        rstOut <= rstOut | STAGES'(1);
                        idx    <= IW'(1);
                        if (STAGES == 1) begin
                            ready <= 1'b1;
                            state <= RUN;
                        end else begin
                            cnt   <= GAP_LD;
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == '0) begin
                        rstOut <= rstOut | (STAGES'(1) << idx);
                        idx    <= idx + 1'b1;
                        if (idx == LAST) begin
                            ready <= 1'b1;
                            state <= RUN;
                        end else begin
                            cnt <= GAP_LD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters.
module tb_reset_sequencer;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       locked;
    logic       swReset;
    logic [2:0] rstOut;
    logic       ready;
    logic [7:0] lockLossCount;

    int n_chk  = 0;
    int n_fail = 0;
    int e      = 0;

    always #5 CLK = ~CLK;

    reset_sequencer dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .locked        (locked),
        .swReset       (swReset),
        .rstOut        (rstOut),
        .ready         (ready),
        .lockLossCount (lockLossCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after edge k of the current timeline.
    task automatic to_edge(input int k);
        while (e < k) begin
            @(posedge CLK);
            e++;
        end
        #1;
    endtask

    initial begin
        nRST = 1'b0; locked = 1'b0; swReset = 1'b0;
        #2;
        chk("rst_rstOut", 32'(rstOut), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_llc", 32'(lockLossCount), 32'h0);
        #10 nRST = 1'b1;

        // Power-up sequence
        @(negedge CLK); locked = 1'b1; e = -1;
        to_edge(17); chk("pu_e17", 32'(rstOut), 32'h0);
        to_edge(18); chk("pu_e18", 32'(rstOut), 32'h1);
        to_edge(21); chk("pu_e21", 32'(rstOut), 32'h1);
        to_edge(22); chk("pu_e22", 32'(rstOut), 32'h3);
        to_edge(25); chk("pu_e25", 32'(rstOut), 32'h3);
        chk("pu_rdy25", 32'(ready), 32'h0);
        to_edge(26); chk("pu_e26", 32'(rstOut), 32'h7);
        chk("pu_rdy26", 32'(ready), 32'h1);

        // Lock loss in RUN at edge 100
        to_edge(99); @(negedge CLK); locked = 1'b0;
        to_edge(101); chk("ll_e101", 32'(rstOut), 32'h7);
        chk("ll_rdy101", 32'(ready), 32'h1);
        to_edge(102); chk("ll_e102", 32'(rstOut), 32'h0);
        chk("ll_rdy102", 32'(ready), 32'h0);
        chk("ll_llc", 32'(lockLossCount), 32'h1);
        @(negedge CLK); locked = 1'b1; e = -1;
        to_edge(17); chk("rl_e17", 32'(rstOut), 32'h0);
        to_edge(18); chk("rl_e18", 32'(rstOut), 32'h1);
        to_edge(26); chk("rl_e26", 32'(rstOut), 32'h7);
        chk("rl_rdy", 32'(ready), 32'h1);

        // Lock loss mid-HOLD (count 5 after edge 12)
        @(negedge CLK); locked = 1'b0; e = -1;
        to_edge(2); chk("mh_llc_pre", 32'(lockLossCount), 32'h2);
        @(negedge CLK); locked = 1'b1; e = -1;
        to_edge(11); @(negedge CLK); locked = 1'b0;
        to_edge(20); chk("mh_e20", 32'(rstOut), 32'h0);
        chk("mh_llc", 32'(lockLossCount), 32'h2);
        to_edge(30); chk("mh_e30", 32'(rstOut), 32'h0);

        // swReset in RELEASE with rstOut=001
        @(negedge CLK); locked = 1'b1; e = -1;
        to_edge(19); chk("sw_e19", 32'(rstOut), 32'h1);
        @(negedge CLK); swReset = 1'b1;
        to_edge(20); swReset = 1'b0;
        chk("sw_e20", 32'(rstOut), 32'h0);
        to_edge(35); chk("sw_e35", 32'(rstOut), 32'h0);
        to_edge(36); chk("sw_e36", 32'(rstOut), 32'h1);
        to_edge(44); chk("sw_e44", 32'(rstOut), 32'h7);
        chk("sw_rdy", 32'(ready), 32'h1);

        // Lock loss and swReset seen together by the FSM in RUN
        @(negedge CLK); locked = 1'b0; e = -1;
        to_edge(1); @(negedge CLK); swReset = 1'b1;
        to_edge(2); swReset = 1'b0;
        chk("both_rstOut", 32'(rstOut), 32'h0);
        chk("both_rdy", 32'(ready), 32'h0);
        chk("both_llc", 32'(lockLossCount), 32'h3);
        to_edge(30); chk("both_e30", 32'(rstOut), 32'h0);

        // Saturation of the lock-loss counter
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK); locked = 1'b1; e = -1; to_edge(30);
            @(negedge CLK); locked = 1'b0; e = -1; to_edge(3);
        end
        chk("sat_103", 32'(lockLossCount), 32'd103);
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK); locked = 1'b1; e = -1; to_edge(30);
            @(negedge CLK); locked = 1'b0; e = -1; to_edge(3);
        end
        chk("sat_255", 32'(lockLossCount), 32'd255);

        // Async reset mid-RELEASE
        @(negedge CLK); locked = 1'b1; e = -1;
        to_edge(23); chk("ar_pre", 32'(rstOut), 32'h3);
        #2 nRST = 1'b0;
        #1;
        chk("ar_rstOut", 32'(rstOut), 32'h0);
        chk("ar_rdy", 32'(ready), 32'h0);
        chk("ar_llc", 32'(lockLossCount), 32'h0);
        @(negedge CLK); nRST = 1'b1; e = -1;
        to_edge(17); chk("ar_e17", 32'(rstOut), 32'h0);
        to_edge(18); chk("ar_e18", 32'(rstOut), 32'h1);
        to_edge(26); chk("ar_e26", 32'(rstOut), 32'h7);
        chk("ar_rdy26", 32'(ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
